player_state_tx: RTL

Serial transmitter that carries the local player's per-frame state to the peer board in two-board play. It sits downstream of the player movement logic and consumes its direction and location outputs plus the chop/carry buttons. Once per video frame it snapshots that state and sends a 5-byte checksummed packet over a single-wire 8N1 link. The peer's link receiver is the matching block on the other end.

---
 rtl/player_state_tx_if.sv | 34 +++
 rtl/player_state_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_state_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : player_state_tx_if
// Description : Port bundle for player_state_tx. The master side supplies the
//               frame trigger and the local player's state; the slave side
//               (the transmitter) returns the serial line and its status.
// Revision    : 1.0 - initial release
// ============================================================================
interface player_state_tx_if;
    logic       vsync;
    logic       enable;
    logic [1:0] player_direction;
    logic [8:0] player_loc_x;
    logic [8:0] player_loc_y;
    logic       chop;
    logic       carry;
    logic       tx;
    logic       busy;
    logic       pkt_sent;
    logic [7:0] drop_count;

    modport master (
        output vsync, enable, player_direction, player_loc_x, player_loc_y,
               chop, carry,
        input  tx, busy, pkt_sent, drop_count
    );

    modport slave (
        input  vsync, enable, player_direction, player_loc_x, player_loc_y,
               chop, carry,
        output tx, busy, pkt_sent, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/player_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : player_state_tx
// Description : Once per video frame, snapshots the local player's direction,
//               location and chop/carry buttons and sends them to the peer
//               board as a 5-byte checksummed packet on a single-wire serial
//               line (start, 8 data bits LSB first, stop).
//               Optional macro PLAYER_TX_PARITY_EN adds an even-parity bit
//               between data bit 7 and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module player_state_tx #(
    parameter int         CLKS_PER_BIT = 565,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  wire              clk,
    input  wire              reset,
    player_state_tx_if.slave bus
);

    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_last_byte = 3'd4;
    localparam logic [2:0]  c_last_bit  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PLAYER_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // vsync synchronizer: [0] and [1] are the two sync flops, [2] is the
    // previous synchronized value used for edge detection.
    logic [2:0]  r_sync;
    logic        w_fall;
    logic        w_start;
    logic        w_drop;

    state_t      r_state;
    state_t      w_state_nx;
    logic [15:0] r_timer;
    logic [15:0] w_timer_nx;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nx;
    logic [2:0]  r_byte;
    logic [2:0]  w_byte_nx;
    logic        w_bit_end;
    logic        w_last_stop;

    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic [7:0]  r_b3;
    logic [7:0]  w_cur_byte;

    logic        r_tx;
    logic        r_busy;
    logic        r_pkt;
    logic [7:0]  r_drop;

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], bus.vsync};
        end
    end

    assign w_fall  = r_sync[2] & ~r_sync[1];
    // The busy flag is still high on the pkt_sent cycle even though the state
    // machine is already back in IDLE, so a trigger there is counted as lost.
    assign w_start = w_fall & bus.enable & ~r_busy & (r_state == S_IDLE);
    assign w_drop  = w_fall & bus.enable & (r_busy | (r_state != S_IDLE));

    // Snapshot the player state into the three payload bytes at packet start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b1 <= 8'h00;
            r_b2 <= 8'h00;
            r_b3 <= 8'h00;
        end else if (w_start) begin
            r_b1 <= {2'b00, bus.carry, bus.chop, bus.player_direction,
                     bus.player_loc_x[8], bus.player_loc_y[8]};
            r_b2 <= bus.player_loc_x[7:0];
            r_b3 <= bus.player_loc_y[7:0];
        end
    end

    // Select the byte currently on the wire; byte 4 is the XOR checksum.
    always_comb begin
        w_cur_byte = SYNC_BYTE;
        case (r_byte)
            3'd1:    w_cur_byte = r_b1;
            3'd2:    w_cur_byte = r_b2;
            3'd3:    w_cur_byte = r_b3;
            3'd4:    w_cur_byte = r_b1 ^ r_b2 ^ r_b3;
            default: w_cur_byte = SYNC_BYTE;
        endcase
    end

    // State register together with the bit timer, bit index and byte index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= 16'd0;
            r_bit   <= 3'd0;
            r_byte  <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_bit   <= w_bit_nx;
            r_byte  <= w_byte_nx;
        end
    end

    assign w_bit_end   = (r_timer == 16'd0);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_byte == c_last_byte);

    // Next-state logic: every non-idle state holds one bit period per bit.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_bit_nx   = r_bit;
        w_byte_nx  = r_byte;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_START;
                    w_timer_nx = c_bit_last;
                    w_bit_nx   = 3'd0;
                    w_byte_nx  = 3'd0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_timer_nx = c_bit_last;
                    w_bit_nx   = 3'd0;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nx = c_bit_last;
                    if (r_bit == c_last_bit) begin
`ifdef PLAYER_TX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
`ifdef PLAYER_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_timer_nx = c_bit_last;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte == c_last_byte) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_START;
                        w_timer_nx = c_bit_last;
                        w_byte_nx  = r_byte + 3'd1;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Line and status flops follow the state one cycle later so tx is a clean
    // register output and busy/pkt_sent line up with what is on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_pkt  <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE);
            r_pkt  <= w_last_stop;
            case (r_state)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= w_cur_byte[r_bit];
`ifdef PLAYER_TX_PARITY_EN
                S_PARITY: r_tx <= ^w_cur_byte;
`endif
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    // Saturating count of enabled triggers lost to an in-flight packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= 8'd0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.pkt_sent   = r_pkt;
    assign bus.drop_count = r_drop;

endmodule
`default_nettype wire
